// File: rtl/layer0_input_packer.sv
// Serial-to-parallel front end for the layer-0 neuron LUTs: quantizes raw sensor words to
// small codes and packs one frame of codes into a double-buffered output register.
module layer0_input_packer #(
  parameter int unsigned IN_WIDTH   = 10,
  parameter int unsigned OUT_BITS   = 2,
  parameter int unsigned NUM_INPUTS = 48,
  parameter int unsigned OFFSET     = 0,
  parameter int unsigned SHIFT      = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_WIDTH-1:0]            in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_INPUTS*OUT_BITS-1:0] out_data,
  output logic                           out_err
);

  localparam int unsigned CntW   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned FrameW = NUM_INPUTS * OUT_BITS;
  localparam logic [CntW-1:0]     LastIdx = CntW'(NUM_INPUTS - 1);
  localparam logic [IN_WIDTH-1:0] Offset  = IN_WIDTH'(OFFSET);
  localparam logic [IN_WIDTH-1:0] CodeMax = IN_WIDTH'((1 << OUT_BITS) - 1);

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [FrameW-1:0]   acc_q, acc_d;
  logic [FrameW-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_err_q, out_err_d;

  // Quantizer: the borrow of the widened subtraction provides the clamp at zero.
  logic                borrow;
  logic [IN_WIDTH-1:0] diff, diff_clamped, scaled;
  logic [OUT_BITS-1:0] code;

  always_comb begin
    {borrow, diff} = {1'b0, in_data} - {1'b0, Offset};
    diff_clamped   = borrow ? '0 : diff;
    scaled         = diff_clamped >> SHIFT;
    code           = (scaled > CodeMax) ? CodeMax[OUT_BITS-1:0] : scaled[OUT_BITS-1:0];
  end

  logic last_slot, full_stall, early_stall, accept, fin;

  assign last_slot   = (cnt_q == LastIdx);
  assign full_stall  = last_slot && out_valid_q && !out_ready;
  // A frame-closing in_last beat must not overwrite a frame that is still held.
  assign early_stall = in_valid && in_last && out_valid_q && !out_ready;
  assign in_ready    = rst && !full_stall && !early_stall;
  assign accept      = in_valid && in_ready;
  assign fin         = accept && (in_last || last_slot);

  logic [FrameW-1:0] frame;

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;

    frame = acc_q;
    frame[cnt_q*OUT_BITS +: OUT_BITS] = code;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (fin) begin
        cnt_d       = '0;
        acc_d       = '0;
        out_data_d  = frame;
        out_valid_d = 1'b1;
        out_err_d   = !(in_last && last_slot);
      end else begin
        cnt_d = cnt_q + CntW'(1);
        acc_d = frame;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_layer0_input_packer.sv
// Bench for layer0_input_packer (4 codes per frame); a second instance with OFFSET=16 shares
// the stimulus so the offset clamp is checked on every frame.
module tb_layer0_input_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [9:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_err;
  logic [7:0] out_data;
  logic       in_ready_b, out_valid_b, out_err_b;
  logic [7:0] out_data_b;

  layer0_input_packer #(
    .IN_WIDTH(10), .OUT_BITS(2), .NUM_INPUTS(4), .OFFSET(0), .SHIFT(3)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err)
  );

  layer0_input_packer #(
    .IN_WIDTH(10), .OUT_BITS(2), .NUM_INPUTS(4), .OFFSET(16), .SHIFT(3)
  ) dut_off (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_err(out_err_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d16;
    logic       err;
  } exp_t;

  typedef struct packed {
    logic [3:0][9:0] w;
    logic [2:0]      n;
    logic            last;
    logic [7:0]      exp_d;
    logic            exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail = 0;
  int   frames_seen = 0;
  int   m_cnt = 0;
  logic [7:0] m_d0 = '0;
  logic [7:0] m_d16 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] quant(input logic [9:0] w, input logic [9:0] off);
    logic [9:0] d;
    d = (w >= off) ? (w - off) : 10'd0;
    d = d >> 3;
    return (d > 10'd3) ? 2'd3 : d[1:0];
  endfunction

  // Drives one beat, waits (bounded) for acceptance, updates the model and pushes the
  // expected frame when the beat closes one.
  task automatic send_beat(input logic [9:0] w, input logic last, input logic use_tbl,
                           input logic [7:0] tbl_d, input logic tbl_err);
    int   t;
    exp_t e;
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    t = 0;
    @(negedge clk);
    while (!(in_ready && in_ready_b) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!(in_ready && in_ready_b)) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_d0[m_cnt*2 +: 2]  = quant(w, 10'd0);
    m_d16[m_cnt*2 +: 2] = quant(w, 10'd16);
    if (last || m_cnt == 3) begin
      e.d0  = use_tbl ? tbl_d : m_d0;
      e.d16 = m_d16;
      e.err = use_tbl ? tbl_err : !(last && m_cnt == 3);
      sb.push_back(e);
      m_cnt = 0;
      m_d0  = '0;
      m_d16 = '0;
    end else begin
      m_cnt++;
    end
  endtask

  // Scoreboard: a frame is consumed at the next rising edge when valid && ready here.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      exp_t e;
      frames_seen++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got data %0h expected no frame", out_data);
      end else begin
        e = sb.pop_front();
        check("frame_data", {24'd0, out_data}, {24'd0, e.d0});
        check("frame_err", {31'd0, out_err}, {31'd0, e.err});
        check("frame_data_off16", {24'd0, out_data_b}, {24'd0, e.d16});
        check("frame_valid_off16", {31'd0, out_valid_b}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{w: {10'd1023, 10'd16, 10'd8, 10'd0}, n: 3'd4, last: 1'b1,
                exp_d: 8'b11_10_01_00, exp_err: 1'b0};
    vecs[1] = '{w: {10'd0, 10'd0, 10'd16, 10'd24}, n: 3'd2, last: 1'b1,
                exp_d: 8'b00_00_10_11, exp_err: 1'b1};
    vecs[2] = '{w: {10'd8, 10'd8, 10'd8, 10'd8}, n: 3'd4, last: 1'b0,
                exp_d: 8'b01_01_01_01, exp_err: 1'b1};
    vecs[3] = '{w: {10'd31, 10'd7, 10'd40, 10'd5}, n: 3'd4, last: 1'b1,
                exp_d: 8'b11_00_11_00, exp_err: 1'b0};
    vecs[4] = '{w: {10'd0, 10'd0, 10'd0, 10'd1023}, n: 3'd1, last: 1'b1,
                exp_d: 8'b00_00_00_11, exp_err: 1'b1};

    // Reset state, including in_ready held low while a word is offered.
    in_valid = 1'b1;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven frames at full throughput.
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < int'(vecs[i].n); b++) begin
        logic lst;
        lst = (b == int'(vecs[i].n) - 1) && vecs[i].last;
        if (i == 0 && b == 3) check("latency_pre", {31'd0, out_valid}, 32'd0);
        send_beat(vecs[i].w[b], lst, 1'b1, vecs[i].exp_d, vecs[i].exp_err);
        if (i == 0 && b == 3) check("latency_post", {31'd0, out_valid}, 32'd1);
      end
    end
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: frame A held, closing beat of frame B stalls.
    out_ready = 1'b0;
    send_beat(10'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    send_beat(10'd8, 1'b0, 1'b0, 8'd0, 1'b0);
    send_beat(10'd16, 1'b0, 1'b0, 8'd0, 1'b0);
    send_beat(10'd1023, 1'b1, 1'b0, 8'd0, 1'b0);
    send_beat(10'd24, 1'b0, 1'b0, 8'd0, 1'b0);
    send_beat(10'd16, 1'b0, 1'b0, 8'd0, 1'b0);
    send_beat(10'd8, 1'b0, 1'b0, 8'd0, 1'b0);
    in_valid = 1'b1;
    in_data  = 10'd0;
    in_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data", {24'd0, out_data}, {24'd0, 8'b11_10_01_00});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat(10'd0, 1'b1, 1'b0, 8'd0, 1'b0);
    check("bp_load_valid", {31'd0, out_valid}, 32'd1);
    check("bp_load_data", {24'd0, out_data}, {24'd0, 8'b00_01_10_11});

    // Early in_last offered while the output is full is held off until out_ready.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 10'd8;
    in_last   = 1'b1;
    @(negedge clk);
    check("early_last_stall", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_beat(10'd8, 1'b1, 1'b0, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-frame discards the partial frame.
    send_beat(10'd24, 1'b0, 1'b0, 8'd0, 1'b0);
    send_beat(10'd24, 1'b0, 1'b0, 8'd0, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", {24'd0, out_data}, 32'd0);
    in_valid = 1'b0;
    m_cnt = 0;
    m_d0  = '0;
    m_d16 = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    begin
      int base;
      base = frames_seen;
      send_beat(10'd8, 1'b0, 1'b0, 8'd0, 1'b0);
      send_beat(10'd16, 1'b0, 1'b0, 8'd0, 1'b0);
      send_beat(10'd1023, 1'b0, 1'b0, 8'd0, 1'b0);
      send_beat(10'd0, 1'b1, 1'b1, 8'b00_11_10_01, 1'b0);
      repeat (4) @(negedge clk);
      check("midrst_frame_count", frames_seen - base, 32'd1);
    end
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
